cp0_except_ctrl: RTL and testbench
==================================

Name: cp0_except_ctrl

Overview:
- Consumer side of the CP0 register block.
- Sits at the MEM stage boundary and reads forwarded CP0 Status/Cause/EPC state.
- Arbitrates pending exceptions and interrupts, then drives the excepttype/inst-addr/delayslot triple back into CP0.
- Generates pipeline flush and the redirect PC; enforces a post-flush lockout window and keeps exception statistics.

Parameters:
EXC_VECTOR, 32'h00000020, redirect PC for every exception except eret
FLUSH_CYCLES, 3, cycles after a taken exception during which new exceptions are masked (1..15)
CNT_W, 16, width of the taken-exception counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
excepttype_i  in  32  MEM-stage raw flags: bit8 syscall, bit9 invalid inst, bit10 trap, bit11 overflow, bit12 eret
current_inst_addr_i  in  32  MEM-stage PC; 0 means bubble
is_in_delayslot_i  in  1  MEM instruction is in a delay slot
cp0_status_i  in  32  CP0 Status (registered value)
cp0_cause_i  in  32  CP0 Cause (registered value)
cp0_epc_i  in  32  CP0 EPC (registered value)
wb_cp0_we_i  in  1  WB stage writing CP0 this cycle
wb_cp0_waddr_i  in  5  WB CP0 write address
wb_cp0_data_i  in  32  WB CP0 write data
excepttype_o  out  32  encoded exception to CP0/ctrl: 0x1 int, 0x8 syscall, 0xa invalid, 0xd trap, 0xc overflow, 0xe eret, 0 none
current_inst_addr_o  out  32  pass-through of current_inst_addr_i
is_in_delayslot_o  out  1  pass-through of is_in_delayslot_i
cp0_epc_o  out  32  forwarded EPC
flush_o  out  1  squash all pipeline stages
new_pc_o  out  32  redirect target, valid when flush_o=1
last_excepttype_o  out  32  registered copy of last nonzero excepttype_o
exc_count_o  out  CNT_W  count of taken exceptions, saturating

Behaviour:
- Forwarding (combinational):
  - Status(12) is replaced wholesale by wb_cp0_data_i.
  - Cause(13) replaces only bits 23, 22 and 9:8; the IP[15:10] bits always come from cp0_cause_i.
  - EPC(14) is replaced wholesale; cp0_epc_o carries the forwarded EPC.
  - Forwarding applies only when wb_cp0_we_i=1.
- Eligibility: no exception is raised when current_inst_addr_i==0 or the FSM is in LOCK.
- Priority, highest first, all evaluated on forwarded values:
  - interrupt: (cause[15:8] & status[15:8]) != 0 && status[0]==1 && status[1]==0
  - syscall, invalid, trap, overflow, eret.
- excepttype_o, flush_o and new_pc_o are combinational in the detection cycle (zero latency), so CP0 updates on the same edge.
- flush_o = (excepttype_o != 0).
- new_pc_o: forwarded EPC when excepttype_o==0xe, otherwise EXC_VECTOR. When flush_o=0, new_pc_o=0.
- FSM states IDLE and LOCK, with a 4-bit lock counter:
  - IDLE -> LOCK on flush_o, loading the counter with FLUSH_CYCLES.
  - In LOCK the counter decrements each cycle; LOCK -> IDLE when the counter reaches 1 at the edge.
  - Flags arriving during LOCK are dropped, not queued. Interrupts remain level-sensitive via Cause and are re-evaluated after LOCK.
- Registered on the flush edge:
  - last_excepttype_o <= excepttype_o.
  - exc_count_o increments and saturates at all-ones; it holds at all-ones.
- Reset (rst=0, asynchronous): FSM=IDLE, counter=0, last_excepttype_o=0, exc_count_o=0. Combinational outputs follow their inputs, with LOCK treated as clear.
- Reset mid-LOCK aborts the lockout immediately.
- Simultaneous WB write to Status clearing IE plus a pending interrupt: no interrupt is taken, because forwarding wins.

Decomposition:
- Shared package/include:
  - exception code constants 0x1/0x8/0xa/0xc/0xd/0xe
  - CP0 register addresses 12/13/14
  - Status bit indices: IE=0, EXL=1, IM=15:8
  - Cause bit indices: IP=15:8, BD=31
- One natural sub-module, cp0_fwd, holds the combinational Status/Cause/EPC forwarding. The FSM, priority logic and counters stay in the top module.

Test Plan:
- Syscall: excepttype_i[8]=1, PC=0x100, status=0x10000001, no WB write -> same cycle excepttype_o=0x8, flush_o=1, new_pc_o=0x20; next edge last_excepttype_o=0x8, exc_count_o=1.
- Eret with forwarding: excepttype_i[12]=1, cp0_epc_i=0x40, WB writes EPC=0x80 -> excepttype_o=0xe, new_pc_o=0x80, cp0_epc_o=0x80.
- Interrupt priority: cause=0x00000400, status=0x00000401, overflow flag set, PC=0x200 -> excepttype_o=0x1. Repeat with WB writing Status=0x00000400 (IE=0) -> excepttype_o=0xc.
- Lockout: syscall at cycle 0 (FLUSH_CYCLES=3), trap flag at cycles 1-3 -> excepttype_o=0 and flush_o=0 in cycles 1-3; trap taken at cycle 4 with excepttype_o=0xd.
- Bubble plus EXL: PC=0 with syscall -> no flush. PC=0x300, status EXL=1, interrupt pending -> no interrupt; syscall still encoded 0x8.
- Reset/saturation: drive rst=0 during LOCK -> immediate IDLE, counters 0. With CNT_W=2, take 5 exceptions -> exc_count_o=3.

Source files
------------

// File: rtl/cp0_except_pkg.sv
// Shared constants for the CP0 exception controller: exception codes, CP0 register
// addresses, Status/Cause bit positions and the lockout FSM state type.
package cp0_except_pkg;

  localparam logic [31:0] ExcNone     = 32'h0000_0000;
  localparam logic [31:0] ExcInt      = 32'h0000_0001;
  localparam logic [31:0] ExcSyscall  = 32'h0000_0008;
  localparam logic [31:0] ExcInvalid  = 32'h0000_000a;
  localparam logic [31:0] ExcOverflow = 32'h0000_000c;
  localparam logic [31:0] ExcTrap     = 32'h0000_000d;
  localparam logic [31:0] ExcEret     = 32'h0000_000e;

  localparam logic [4:0] Cp0RegStatus = 5'd12;
  localparam logic [4:0] Cp0RegCause  = 5'd13;
  localparam logic [4:0] Cp0RegEpc    = 5'd14;

  localparam int unsigned StatusIe   = 0;
  localparam int unsigned StatusExl  = 1;
  localparam int unsigned StatusImHi = 15;
  localparam int unsigned StatusImLo = 8;

  localparam int unsigned CauseIpHi = 15;
  localparam int unsigned CauseIpLo = 8;
  localparam int unsigned CauseIv   = 23;
  localparam int unsigned CauseWp   = 22;
  localparam int unsigned CauseBd   = 31;

  // Raw MEM-stage flag positions in excepttype_i.
  localparam int unsigned FlagSyscall  = 8;
  localparam int unsigned FlagInvalid  = 9;
  localparam int unsigned FlagTrap     = 10;
  localparam int unsigned FlagOverflow = 11;
  localparam int unsigned FlagEret     = 12;

  typedef enum logic [0:0] {
    StIdle,
    StLock
  } lock_state_e;

endpackage

// File: rtl/cp0_except_ctrl_fwd.sv
// Combinational WB->MEM forwarding of CP0 Status, Cause and EPC so exception decisions
// see a CP0 write that is retiring in the same cycle.
module cp0_fwd
  import cp0_except_pkg::*;
(
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  always_comb begin
    status_o = status_i;
    cause_o  = cause_i;
    epc_o    = epc_i;
    if (we_i) begin
      unique case (waddr_i)
        Cp0RegStatus: status_o = wdata_i;
        // Only software-writable Cause fields; hardware IP bits stay live.
        Cp0RegCause: begin
          cause_o[CauseIv]   = wdata_i[CauseIv];
          cause_o[CauseWp]   = wdata_i[CauseWp];
          cause_o[9:8]       = wdata_i[9:8];
        end
        Cp0RegEpc:    epc_o = wdata_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cp0_except_ctrl.sv
// MEM-stage exception arbiter: prioritises interrupts and exception flags, drives the
// encoded exception back to CP0, flushes/redirects the pipeline and locks out re-entry.
module cp0_except_ctrl
  import cp0_except_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      current_inst_addr_i,
  input  logic             is_in_delayslot_i,
  input  logic [31:0]      cp0_status_i,
  input  logic [31:0]      cp0_cause_i,
  input  logic [31:0]      cp0_epc_i,
  input  logic             wb_cp0_we_i,
  input  logic [4:0]       wb_cp0_waddr_i,
  input  logic [31:0]      wb_cp0_data_i,
  output logic [31:0]      excepttype_o,
  output logic [31:0]      current_inst_addr_o,
  output logic             is_in_delayslot_o,
  output logic [31:0]      cp0_epc_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic [31:0]      last_excepttype_o,
  output logic [CNT_W-1:0] exc_count_o
);

  logic [31:0] status_fwd, cause_fwd, epc_fwd;

  cp0_fwd u_fwd (
    .status_i (cp0_status_i),
    .cause_i  (cp0_cause_i),
    .epc_i    (cp0_epc_i),
    .we_i     (wb_cp0_we_i),
    .waddr_i  (wb_cp0_waddr_i),
    .wdata_i  (wb_cp0_data_i),
    .status_o (status_fwd),
    .cause_o  (cause_fwd),
    .epc_o    (epc_fwd)
  );

  lock_state_e      state_q, state_d;
  logic [3:0]       lock_cnt_q, lock_cnt_d;
  logic [31:0]      last_exc_q, last_exc_d;
  logic [CNT_W-1:0] exc_cnt_q, exc_cnt_d;

  logic irq_pending;
  logic eligible;

  logic unused_bits;
  assign unused_bits = ^{excepttype_i[31:13], excepttype_i[7:0], status_fwd[31:16],
                         status_fwd[7:2], cause_fwd[31:16], cause_fwd[7:0]};

  assign irq_pending = (|(cause_fwd[CauseIpHi:CauseIpLo] & status_fwd[StatusImHi:StatusImLo]))
                       && status_fwd[StatusIe] && !status_fwd[StatusExl];
  assign eligible    = (current_inst_addr_i != 32'h0) && (state_q != StLock);

  always_comb begin
    excepttype_o = ExcNone;
    if (eligible) begin
      if (irq_pending)                       excepttype_o = ExcInt;
      else if (excepttype_i[FlagSyscall])    excepttype_o = ExcSyscall;
      else if (excepttype_i[FlagInvalid])    excepttype_o = ExcInvalid;
      else if (excepttype_i[FlagTrap])       excepttype_o = ExcTrap;
      else if (excepttype_i[FlagOverflow])   excepttype_o = ExcOverflow;
      else if (excepttype_i[FlagEret])       excepttype_o = ExcEret;
    end
    flush_o = (excepttype_o != ExcNone);
    if (!flush_o)                    new_pc_o = 32'h0;
    else if (excepttype_o == ExcEret) new_pc_o = epc_fwd;
    else                             new_pc_o = EXC_VECTOR;
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    last_exc_d = last_exc_q;
    exc_cnt_d  = exc_cnt_q;
    case (state_q)
      StIdle: begin
        if (flush_o) begin
          state_d    = StLock;
          lock_cnt_d = 4'(FLUSH_CYCLES);
          last_exc_d = excepttype_o;
          if (exc_cnt_q != {CNT_W{1'b1}}) exc_cnt_d = exc_cnt_q + 1'b1;
        end
      end
      StLock: begin
        if (lock_cnt_q <= 4'd1) begin
          state_d    = StIdle;
          lock_cnt_d = 4'd0;
        end else begin
          lock_cnt_d = lock_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d    = StIdle;
        lock_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      lock_cnt_q <= 4'd0;
      last_exc_q <= 32'h0;
      exc_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      last_exc_q <= last_exc_d;
      exc_cnt_q  <= exc_cnt_d;
    end
  end

  assign current_inst_addr_o = current_inst_addr_i;
  assign is_in_delayslot_o   = is_in_delayslot_i;
  assign cp0_epc_o           = epc_fwd;
  assign last_excepttype_o   = last_exc_q;
  assign exc_count_o         = exc_cnt_q;

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Scoreboard bench for cp0_except_ctrl: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares. A second CNT_W=2 instance checks saturation.
module tb_cp0_except_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] excepttype_i = '0, current_inst_addr_i = '0;
  logic        is_in_delayslot_i = 1'b0;
  logic [31:0] cp0_status_i = '0, cp0_cause_i = '0, cp0_epc_i = '0;
  logic        wb_cp0_we_i = 1'b0;
  logic [4:0]  wb_cp0_waddr_i = '0;
  logic [31:0] wb_cp0_data_i = '0;

  logic [31:0] excepttype_o, current_inst_addr_o, cp0_epc_o, new_pc_o, last_excepttype_o;
  logic        is_in_delayslot_o, flush_o;
  logic [15:0] exc_count_o;

  logic [31:0] s_excepttype_o, s_addr_o, s_epc_o, s_new_pc_o, s_last_o;
  logic        s_ds_o, s_flush_o;
  logic [1:0]  s_count_o;

  always #5 clk = ~clk;

  cp0_except_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .excepttype_i(excepttype_i),
    .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .cp0_epc_o(cp0_epc_o), .flush_o(flush_o),
    .new_pc_o(new_pc_o), .last_excepttype_o(last_excepttype_o), .exc_count_o(exc_count_o)
  );

  cp0_except_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .excepttype_i(excepttype_i),
    .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
    .excepttype_o(s_excepttype_o), .current_inst_addr_o(s_addr_o),
    .is_in_delayslot_o(s_ds_o), .cp0_epc_o(s_epc_o), .flush_o(s_flush_o),
    .new_pc_o(s_new_pc_o), .last_excepttype_o(s_last_o), .exc_count_o(s_count_o)
  );

  typedef struct {
    int          id;
    logic [31:0] etype;
    logic        flush;
    logic [31:0] npc;
    logic [31:0] epc;
    logic [31:0] addr;
    logic        ds;
    logic [31:0] last;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   vec   = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL vec%0d %s: got %h want %h", id, name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("excepttype", e.id, excepttype_o, e.etype);
      chk("flush", e.id, {31'h0, flush_o}, {31'h0, e.flush});
      chk("new_pc", e.id, new_pc_o, e.npc);
      chk("epc_fwd", e.id, cp0_epc_o, e.epc);
      chk("addr_pass", e.id, current_inst_addr_o, e.addr);
      chk("ds_pass", e.id, {31'h0, is_in_delayslot_o}, {31'h0, e.ds});
      chk("last_exc", e.id, last_excepttype_o, e.last);
      chk("exc_count", e.id, {16'h0, exc_count_o}, {16'h0, e.cnt});
      chk("sat_count", e.id, {30'h0, s_count_o}, {30'h0, e.cnt2});
    end
  end

  // One cycle: drive inputs just after posedge, queue what the monitor must see at negedge.
  task automatic step(input logic r, input logic [31:0] exc, input logic [31:0] pc,
                      input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ds, input logic [31:0] x_type, input logic [31:0] x_npc,
                      input logic [31:0] x_epc, input logic [31:0] x_last,
                      input logic [15:0] x_cnt, input logic [1:0] x_cnt2);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; excepttype_i = exc; current_inst_addr_i = pc; cp0_status_i = st;
    cp0_cause_i = ca; cp0_epc_i = ep; wb_cp0_we_i = we; wb_cp0_waddr_i = wa;
    wb_cp0_data_i = wd; is_in_delayslot_i = ds;
    vec++;
    e.id = vec; e.etype = x_type; e.flush = (x_type != 0); e.npc = x_npc; e.epc = x_epc;
    e.addr = pc; e.ds = ds; e.last = x_last; e.cnt = x_cnt; e.cnt2 = x_cnt2;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [31:0] x_last, input logic [15:0] x_cnt,
                      input logic [1:0] x_cnt2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x_last, x_cnt, x_cnt2);
  endtask

  initial begin
    // Reset held, then released
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0);
    // Syscall
    step(1, 32'h100, 32'h100, 32'h1000_0001, 0, 0, 0, 0, 0, 0,
         32'h8, 32'h20, 0, 0, 0, 0);
    repeat (3) idle(32'h8, 1, 1);
    // Eret with EPC forwarded from WB
    step(1, 32'h1000, 32'h104, 0, 0, 32'h40, 1, 5'd14, 32'h80, 0,
         32'he, 32'h80, 32'h80, 32'h8, 1, 1);
    repeat (3) idle(32'he, 2, 2);
    // Interrupt beats overflow
    step(1, 32'h800, 32'h200, 32'h401, 32'h400, 0, 0, 0, 0, 0,
         32'h1, 32'h20, 0, 32'he, 2, 2);
    repeat (3) idle(32'h1, 3, 3);
    // WB clears IE in the same cycle: overflow wins
    step(1, 32'h800, 32'h200, 32'h401, 32'h400, 0, 1, 5'd12, 32'h400, 0,
         32'hc, 32'h20, 0, 32'h1, 3, 3);
    // Trap flag held through the lockout window is dropped, then taken
    repeat (3) step(1, 32'h400, 32'h210, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hc, 4, 3);
    step(1, 32'h400, 32'h210, 0, 0, 0, 0, 0, 0, 0, 32'hd, 32'h20, 0, 32'hc, 4, 3);
    repeat (3) idle(32'hd, 5, 3);
    // Bubble with syscall: no flush
    step(1, 32'h100, 0, 32'h401, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hd, 5, 3);
    // EXL masks the pending interrupt; syscall still taken
    step(1, 32'h100, 32'h300, 32'h403, 32'h400, 0, 0, 0, 0, 1,
         32'h8, 32'h20, 0, 32'hd, 5, 3);
    // Reset asserted inside LOCK: registers clear and lockout is gone immediately
    step(0, 32'h100, 32'h400, 32'h1, 0, 0, 0, 0, 0, 0, 32'h8, 32'h20, 0, 0, 0, 0);
    idle(0, 0, 0);
    // Cause forwarding sets IP0 from WB data
    step(1, 0, 32'h500, 32'h101, 0, 0, 1, 5'd13, 32'h100, 0,
         32'h1, 32'h20, 0, 0, 0, 0);
    repeat (3) idle(32'h1, 1, 1);
    // Cause forwarding must not touch IP[15:10]
    step(1, 0, 32'h504, 32'h401, 0, 0, 1, 5'd13, 32'h400, 0, 0, 0, 0, 32'h1, 1, 1);
    // EPC not forwarded without write enable
    step(1, 0, 32'h508, 0, 0, 32'h1234, 0, 5'd14, 32'h80, 1, 0, 0, 32'h1234, 32'h1, 1, 1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
